pcm_frame_receiver: RTL
=======================

// Module: pcm_frame_receiver
// PURPOSE
//  Receive end of the PCM-over-Ethernet link. Takes the byte stream from the Ethernet
//  receiver, skips the header and checks the frame, then unpacks the little-endian
//  16-bit multichannel PCM payload into a ping-pong buffer.
//  On each PCM strobe it plays out one sample set as a 16-cycle channel burst.
//  Sits between the Ethernet RX deframer and the audio output / DAC path.
// PARAMETERS
//  HDR_LEN   14      header bytes skipped before payload (MAC dst/src + ethertype)
//  NCHAN     16      channels per sample set (power of 2)
//  NSETS     16      sample sets per frame; payload = NCHAN*NSETS*2 = 512 bytes
//  ETHERTYPE 16'h88B5 expected ethertype (only used with PCM_RX_ETYPE_FILTER_EN)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  rx_valid    in   1   rx_data holds a valid byte this cycle
//  rx_data     in   8   received byte (FCS already stripped)
//  rx_sof      in   1   qualifies the first byte of a frame (with rx_valid)
//  rx_eof      in   1   end-of-frame pulse, 1 cycle, after the last byte
//  rx_crc_ok   in   1   FCS check result, sampled with rx_eof
//  pcm_stb     in   1   1-cycle sample-rate strobe
//  out_valid   out  1   out_sample/out_chan valid
//  out_chan    out  4   channel index 0..NCHAN-1
//  out_sample  out  16  signed PCM sample
//  underrun    out  1   1-cycle pulse: pcm_stb arrived with no bank ready
//  drop_cnt    out  8   saturating count of dropped frames
// BEHAVIOUR
//  Reset: all outputs 0. Both banks empty, wr_bank=0, rd_bank=0, RX FSM in IDLE.
//  RX FSM: IDLE -> HDR -> PAY -> WAIT_EOF -> IDLE.
//   - IDLE: rx_valid&rx_sof starts a frame and counts byte 0.
//     If no bank is free, go to DISCARD; the frame is dropped.
//   - HDR: count bytes up to HDR_LEN-1, then go to PAY.
//   - PAY: byte n of the payload goes to address n of wr_bank, 1 cycle after rx_valid.
//     Sample k is {byte 2k+1, byte 2k}; set s, channel c is k = s*NCHAN + c.
//   - After 512 payload bytes, go to WAIT_EOF. Any further rx_valid there is a length error.
//   - rx_eof in WAIT_EOF with rx_crc_ok=1 and no length error marks wr_bank full
//     the next cycle, and wr_bank toggles.
//   - Drop the frame and increment drop_cnt (saturates at 255) on any of: rx_eof before
//     the payload completes, rx_crc_ok=0, length error, no bank free.
//     A dropped frame leaves wr_bank not full.
//   - rx_sof while a frame is in progress aborts that frame (counted as a drop)
//     and starts a new one on the same byte.
//  Playout:
//   - On pcm_stb with rd_bank full, set S is read starting the next cycle.
//     out_valid is high for NCHAN consecutive cycles with out_chan 0..15,
//     and out_sample is the sample for each channel.
//   - After set NSETS-1, rd_bank becomes empty and rd_bank toggles.
//   - pcm_stb with rd_bank empty: the burst outputs zeros for all channels and
//     underrun pulses for 1 cycle.
//   - pcm_stb during an active burst is ignored; there is no underrun.
//  Simultaneous events: the same-cycle bank-full mark (RX) and bank release (playout)
//  act on different banks and both take effect. The buffer is a true dual-port
//  2*NCHAN*NSETS x 16 memory, with 1-cycle read latency absorbed in the burst pipeline.
//  Reset mid-frame or mid-burst: the partial frame is lost, out_valid drops
//  immediately, and both banks become empty.
// CONFIGURATION
//  PCM_RX_ETYPE_FILTER_EN
//   - Defined: header bytes 12,13 must equal ETHERTYPE[15:8], ETHERTYPE[7:0].
//     On mismatch the frame goes to DISCARD and drop_cnt increments.
//   - Undefined: header bytes are ignored entirely and the ETHERTYPE parameter is unused.
// TESTING
//  1 Good frame: 14 hdr + bytes payload[n]=n&255, crc_ok=1, then pcm_stb ->
//    out_chan 0..15 with out_sample 16'h0100, 16'h0302, ..., 16'h1F1E.
//  2 16 pcm_stb after one good frame -> 16 bursts; the last burst set 15 starts 16'hE1E0.
//    The 17th pcm_stb gives zeros and underrun=1.
//  3 Frame with crc_ok=0 -> drop_cnt=1, no bank full; pcm_stb -> underrun.
//  4 Three good frames back-to-back with no pcm_stb -> frames 1 and 2 stored,
//    frame 3 dropped (drop_cnt=1).
//  5 rx_sof after 100 payload bytes, then a full good frame -> drop_cnt=1 and
//    the second frame plays out correctly.
//  6 Filter defined, header bytes 12-13 = 08 00 -> frame dropped. Repeat with
//    88 B5 -> frame accepted. Plus rst_n pulse mid-burst -> out_valid=0 within 0 cycles.

Source files
------------

// File: rtl/pcm_frame_receiver.sv
// rtl/pcm_frame_receiver.sv - PCM-over-Ethernet frame receiver with ping-pong playout buffer
//
// Purpose:
//   Takes the byte stream from the Ethernet RX deframer. It skips the HDR_LEN-byte
//   header and checks the frame length and FCS result. It then unpacks the
//   little-endian 16-bit PCM payload (NSETS sample sets of NCHAN channels) into one
//   bank of a two-bank buffer. Each pcm_stb plays out one sample set as an NCHAN-cycle
//   burst. When no bank is ready the burst carries zeros and underrun pulses.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   rx_valid, rx_data   received byte stream (FCS already stripped)
//   rx_sof              marks the first byte of a frame (qualified by rx_valid)
//   rx_eof, rx_crc_ok   end-of-frame pulse after the last byte, with the FCS result
//   pcm_stb             sample-rate strobe, one cycle
//   out_valid, out_chan, out_sample   playout burst, channels 0..NCHAN-1
//   underrun            one-cycle pulse when pcm_stb finds no bank ready
//   drop_cnt            saturating count of dropped frames
//
// Build option:
//   PCM_RX_ETYPE_FILTER_EN  when defined, header bytes 12 and 13 must match ETHERTYPE
//                           or the frame is discarded. When undefined, header content
//                           is ignored.

module pcm_frame_receiver #(
  parameter int          HDR_LEN   = 14,
  parameter int          NCHAN     = 16,
  parameter int          NSETS     = 16,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_sof,
  input  logic                     rx_eof,
  input  logic                     rx_crc_ok,
  input  logic                     pcm_stb,
  output logic                     out_valid,
  output logic [$clog2(NCHAN)-1:0] out_chan,
  output logic [15:0]              out_sample,
  output logic                     underrun,
  output logic [7:0]               drop_cnt
);

  localparam int CH_W      = $clog2(NCHAN);
  localparam int SET_W     = $clog2(NSETS);
  localparam int PAY_BYTES = NCHAN * NSETS * 2;
  localparam int PAY_W     = $clog2(PAY_BYTES);
  localparam int ADDR_W    = 1 + SET_W + CH_W;   // {bank, set, channel}
  localparam int MEM_WORDS = 2 * NCHAN * NSETS;
  localparam int HDR_W     = $clog2(HDR_LEN);

  localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(HDR_LEN - 1);
  localparam logic [PAY_W-1:0] PAY_LAST = PAY_W'(PAY_BYTES - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCHAN - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(NSETS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_WAIT_EOF,
    S_DISCARD
  } rx_state_t;

  rx_state_t state_q, state_d;

  logic [HDR_W-1:0] hdr_cnt_q;
  logic [PAY_W-1:0] pay_cnt_q;
  logic             len_err_q;
  logic             wr_bank_q;
  logic             rd_bank_q;
  logic [1:0]       bank_full_q;

  logic frame_start;
  logic bank_free;
  logic hdr_done;
  logic in_frame;
  logic etype_ok;
  logic drop_evt;
  logic commit;
  logic pay_byte;

  assign frame_start = rx_valid & rx_sof;
  // wr_bank only advances on a commit, so it always names the bank the next frame would fill
  assign bank_free   = ~bank_full_q[wr_bank_q];
  assign hdr_done    = rx_valid & (hdr_cnt_q == HDR_LAST);
  assign in_frame    = (state_q == S_HDR) | (state_q == S_PAY) | (state_q == S_WAIT_EOF);

  // ---------------------------------------------------------------------------
  // Ethertype check
  // ---------------------------------------------------------------------------
`ifdef PCM_RX_ETYPE_FILTER_EN
  localparam logic [HDR_W-1:0] ETYPE_HI_IDX = HDR_W'(12);
  localparam logic [HDR_W-1:0] ETYPE_LO_IDX = HDR_W'(13);

  logic etype_ok_q;
  logic etype_byte_ok;

  always_comb begin
    etype_byte_ok = 1'b1;
    if (hdr_cnt_q == ETYPE_HI_IDX) etype_byte_ok = (rx_data == ETHERTYPE[15:8]);
    if (hdr_cnt_q == ETYPE_LO_IDX) etype_byte_ok = (rx_data == ETHERTYPE[7:0]);
  end

  // Running AND of the per-byte matches. The last header byte is folded in live,
  // so the accept/discard decision is made on that byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      etype_ok_q <= 1'b1;
    end else if (frame_start) begin
      etype_ok_q <= 1'b1;
    end else if (state_q == S_HDR && rx_valid) begin
      etype_ok_q <= etype_ok_q & etype_byte_ok;
    end
  end

  assign etype_ok = etype_ok_q & etype_byte_ok;
`else
  logic unused_etype;
  assign unused_etype = ^ETHERTYPE;
  assign etype_ok     = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // RX FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM: next state. A start-of-frame byte restarts reception from any state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = bank_free ? S_HDR : S_DISCARD;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_HDR: begin
          if (rx_eof)        state_d = S_IDLE;
          else if (hdr_done) state_d = etype_ok ? S_PAY : S_DISCARD;
        end
        S_PAY: begin
          if (rx_eof)                               state_d = S_IDLE;
          else if (rx_valid && pay_cnt_q == PAY_LAST) state_d = S_WAIT_EOF;
        end
        S_WAIT_EOF: if (rx_eof) state_d = S_IDLE;
        S_DISCARD:  if (rx_eof) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM: outputs (drop, commit, payload byte strobe)
  // ---------------------------------------------------------------------------
  always_comb begin
    drop_evt = 1'b0;
    commit   = 1'b0;
    pay_byte = 1'b0;
    if (frame_start) begin
      // Aborting a frame in progress counts as a drop. A frame already in DISCARD
      // was counted when it entered DISCARD.
      drop_evt = in_frame | ~bank_free;
    end else begin
      case (state_q)
        S_HDR: drop_evt = rx_eof | (hdr_done & ~etype_ok);
        S_PAY: begin
          drop_evt = rx_eof;
          pay_byte = rx_valid & ~rx_eof;
        end
        S_WAIT_EOF: begin
          if (rx_eof) begin
            if (rx_crc_ok && !len_err_q && !rx_valid) commit   = 1'b1;
            else                                      drop_evt = 1'b1;
          end
        end
        default: begin
          drop_evt = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame byte counters and length-error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else if (frame_start) begin
      hdr_cnt_q <= HDR_W'(1);   // the SOF byte is header byte 0
      pay_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (state_q == S_HDR && rx_valid) hdr_cnt_q <= hdr_cnt_q + 1'b1;
      if (pay_byte)                     pay_cnt_q <= pay_cnt_q + 1'b1;
      if (state_q == S_WAIT_EOF && rx_valid) len_err_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload write port: payload byte n lands in byte lane n[0] of word n/2 of
  // wr_bank one cycle after it arrives. Even bytes are the low lanes, which
  // gives little-endian samples.
  // ---------------------------------------------------------------------------
  logic              wr_en_q;
  logic              wr_hi_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_byte_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_hi_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_byte_q <= '0;
    end else begin
      wr_en_q <= pay_byte;
      if (pay_byte) begin
        wr_hi_q   <= pay_cnt_q[0];
        wr_addr_q <= {wr_bank_q, pay_cnt_q[PAY_W-1:1]};
        wr_byte_q <= rx_data;
      end
    end
  end

  logic [15:0] mem [0:MEM_WORDS-1];

  always_ff @(posedge clk) begin
    if (wr_en_q) begin
      if (wr_hi_q) mem[wr_addr_q][15:8] <= wr_byte_q;
      else         mem[wr_addr_q][7:0]  <= wr_byte_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Playout: a burst issues NCHAN reads on consecutive cycles. The read data
  // register and the out_* registers load together, so the memory latency is
  // hidden in the burst pipeline.
  // ---------------------------------------------------------------------------
  logic             burst_q;
  logic             zero_q;
  logic [CH_W-1:0]  rd_cnt_q;
  logic [SET_W-1:0] rd_set_q;
  logic             out_zero_q;
  logic [15:0]      rd_q;
  logic             burst_start;
  logic             burst_last;
  logic             release_bank;

  assign burst_start  = pcm_stb & ~burst_q;
  assign burst_last   = burst_q & (rd_cnt_q == CH_LAST);
  assign release_bank = burst_last & ~zero_q & (rd_set_q == SET_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q    <= 1'b0;
      zero_q     <= 1'b0;
      rd_cnt_q   <= '0;
      rd_set_q   <= '0;
      rd_bank_q  <= 1'b0;
      underrun   <= 1'b0;
      out_valid  <= 1'b0;
      out_chan   <= '0;
      out_zero_q <= 1'b0;
    end else begin
      underrun <= burst_start & ~bank_full_q[rd_bank_q];
      if (burst_start) begin
        burst_q  <= 1'b1;
        rd_cnt_q <= '0;
        zero_q   <= ~bank_full_q[rd_bank_q];
      end else if (burst_q) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
        if (burst_last) begin
          burst_q <= 1'b0;
          // A zero-filled burst consumes nothing, so the set pointer stays put
          if (!zero_q) begin
            if (rd_set_q == SET_LAST) begin
              rd_set_q  <= '0;
              rd_bank_q <= ~rd_bank_q;
            end else begin
              rd_set_q <= rd_set_q + 1'b1;
            end
          end
        end
      end
      out_valid  <= burst_q;
      out_chan   <= rd_cnt_q;
      out_zero_q <= zero_q;
    end
  end

  always_ff @(posedge clk) begin
    rd_q <= mem[{rd_bank_q, rd_set_q, rd_cnt_q}];
  end

  // The RAM read register is not reset. Gating with out_valid keeps the sample at
  // zero during and after reset, and outside bursts.
  assign out_sample = (out_valid && !out_zero_q) ? rd_q : 16'h0000;

  // ---------------------------------------------------------------------------
  // Bank ownership and drop counter. A commit and a release in the same cycle
  // always target different banks, so both masks apply together.
  // ---------------------------------------------------------------------------
  logic [1:0] set_mask;
  logic [1:0] clr_mask;

  assign set_mask = commit       ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask = release_bank ? (rd_bank_q ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      drop_cnt    <= 8'h00;
    end else begin
      bank_full_q <= (bank_full_q & ~clr_mask) | set_mask;
      if (commit) wr_bank_q <= ~wr_bank_q;
      if (drop_evt && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
